vexriscv_dbus_responder: RTL
============================

VEXRISCV_DBUS_RESPONDER -- requirements
Module: vexriscv_dbus_responder

Interface
REQ-001 Parameter MEM_WORDS, default 16: memory depth in 32-bit words; power of two, 2..64.
REQ-002 Parameter LATENCY, default 2: idle cycles between read acceptance and response; 0..15.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 dBus_cmd_valid  input  1  initiator presents a command.
REQ-006 dBus_cmd_ready  output  1  responder accepts the command this cycle.
REQ-007 dBus_cmd_payload_wr  input  1  1 = store, 0 = load.
REQ-008 dBus_cmd_payload_address  input  32  byte address.
REQ-009 dBus_cmd_payload_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 dBus_cmd_payload_size  input  2  0 = byte, 1 = half, 2 = word; 3 reserved.
REQ-011 dBus_rsp_ready  output  1  single-cycle load-response strobe.
REQ-012 dBus_rsp_data  output  32  aligned word containing the addressed bytes.
REQ-013 dBus_rsp_error  output  1  load response is an error; valid only with dBus_rsp_ready.

Function
REQ-014 Acceptance: a command is accepted at a rising edge where dBus_cmd_valid and dBus_cmd_ready are both 1.
REQ-015 States: IDLE, WAIT, RESP.
REQ-016 dBus_cmd_ready = 1 only in IDLE with resetn high; 0 in WAIT and RESP.
REQ-017 IDLE + accepted load: go to WAIT when LATENCY > 0; go directly to RESP when LATENCY = 0.
REQ-018 On load acceptance, latch the response word and error flag from memory state at that edge. A store in the same edge is impossible (REQ-016).
REQ-019 WAIT: a down-counter loaded with LATENCY-1 at acceptance decrements each cycle; on the edge where it reads 0, go to RESP.
REQ-020 RESP lasts exactly one cycle:
  - rsp_ready = 1 with the latched data and error;
  - then return to IDLE.
  - Minimum load turnaround (accept to next accept) is LATENCY+2 cycles.
REQ-021 Load word index = address[log2(MEM_WORDS)+1:2]; rsp_data = the full stored word. The initiator performs byte/half extraction.
REQ-022 Load error conditions:
  - misaligned (size 1 with address[0] = 1, or size 2 with address[1:0] != 0);
  - size = 3;
  - address >= 4*MEM_WORDS.
  On error, rsp_error = 1 and rsp_data = 0.
REQ-023 Stores generate no response and keep state IDLE. Memory updates at the acceptance edge, so back-to-back stores are accepted every cycle.
REQ-024 Store byte enables:
  - size 0: lane address[1:0] gets data[7:0];
  - size 1: lanes {address[1],0} and {address[1],1} get data[15:0];
  - size 2: all lanes get data[31:0].
REQ-025 Stores that are misaligned, size 3 or out of range are accepted and discarded; memory is unchanged.
REQ-026 When rsp_ready = 0, rsp_data and rsp_error are 0.
REQ-027 dBus_cmd_valid while not ready has no effect; no command is queued.

Reset
REQ-028 While resetn is low:
  - state = IDLE, counter = 0;
  - all memory words = 0;
  - cmd_ready = 0, rsp_ready = 0, rsp_data = 0, rsp_error = 0.
REQ-029 Reset asserted mid-load (WAIT or RESP) aborts the load; no response is produced after reset release.
REQ-030 First acceptance is possible at the first rising edge after resetn deasserts.

Verification
REQ-031 LATENCY=2: store word 0xDEADBEEF @0x8, then load @0x8 accepted at edge T -> rsp_ready high only in cycle T+3, data 0xDEADBEEF, error 0; cmd_ready low in cycles T+1..T+3.
REQ-032 Byte stores 0x11 @0x4 and 0x22 @0x7 (data 0x00000022), then word load @0x4 -> rsp_data 0x22000011.
REQ-033 Load @0x2 size 2 -> rsp_error 1, rsp_data 0. Load @0x40 with MEM_WORDS=16 -> rsp_error 1. Half store @0x1 -> memory unchanged.
REQ-034 LATENCY=0: load accepted at T -> rsp in T+1, cmd_ready high again in T+2. Four consecutive stores each accepted on consecutive edges.
REQ-035 resetn pulsed low during WAIT -> no rsp_ready ever; memory reads 0 afterwards; cmd_ready 1 in the first cycle after release.

Source files
------------

// File: rtl/vexriscv_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : vexriscv_dbus_responder
// Description : VexRiscv simple dBus target with a small word memory and a
//               fixed load latency.
// Revision    : 1.0
// ============================================================================
module vexriscv_dbus_responder #(
  parameter int MEM_WORDS = 16,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_error
);

  localparam int         c_AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] c_CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [31:0]       r_mem [MEM_WORDS];
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;

  logic [c_AW-1:0]   w_idx;
  logic              w_oor;
  logic              w_err;
  logic              w_accept;
  logic              w_load;
  logic              w_store;
  logic [31:0]       w_mask;
  logic [31:0]       w_wdata;

  assign w_idx    = dBus_cmd_payload_address[c_AW+1:2];
  assign w_oor    = |dBus_cmd_payload_address[31:c_AW+2];
  assign w_err    = w_oor
                  || (dBus_cmd_payload_size == 2'd3)
                  || (dBus_cmd_payload_size == 2'd1 && dBus_cmd_payload_address[0])
                  || (dBus_cmd_payload_size == 2'd2 && dBus_cmd_payload_address[1:0] != 2'd0);

  assign dBus_cmd_ready = (r_state == S_IDLE) && resetn;
  assign w_accept       = dBus_cmd_valid && dBus_cmd_ready;
  assign w_load         = w_accept && !dBus_cmd_payload_wr;
  assign w_store        = w_accept && dBus_cmd_payload_wr && !w_err;

  // Store data is replicated across lanes so the byte mask alone selects it.
  always_comb begin
    w_mask  = 32'h0;
    w_wdata = dBus_cmd_payload_data;
    case (dBus_cmd_payload_size)
      2'd0: begin
        w_mask  = 32'h0000_00FF << {dBus_cmd_payload_address[1:0], 3'b000};
        w_wdata = {4{dBus_cmd_payload_data[7:0]}};
      end
      2'd1: begin
        w_mask  = dBus_cmd_payload_address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wdata = {2{dBus_cmd_payload_data[15:0]}};
      end
      2'd2:    w_mask = 32'hFFFF_FFFF;
      default: w_mask = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 4'd0;
    end else if (w_load) begin
      r_cnt <= c_CNT_LOAD;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response is captured at acceptance so later stores cannot alter it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rsp_data <= 32'h0;
      r_rsp_err  <= 1'b0;
    end else if (w_load) begin
      r_rsp_err  <= w_err;
      r_rsp_data <= w_err ? 32'h0 : r_mem[w_idx];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (w_store) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_wdata & w_mask);
    end
  end

  assign dBus_rsp_ready = (r_state == S_RESP);
  assign dBus_rsp_data  = dBus_rsp_ready ? r_rsp_data : 32'h0;
  assign dBus_rsp_error = dBus_rsp_ready && r_rsp_err;

endmodule
`default_nettype wire
